run_ctrl: RTL and testbench

RUN_CTRL -- requirements
Module: run_ctrl

---
 rtl/run_ctrl.sv | 157 +++++++++++++++
 tb/tb_run_ctrl.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/run_ctrl.sv
// Run controller: resets the processor, runs it until halt or timeout, drains, then dumps dmem words.
// The dump stream is valid/ready; a stalled word is held stable until the sink accepts it.
module run_ctrl #(
  parameter logic [31:0] RESET_CYCLES = 32'd1,
  parameter logic [31:0] DRAIN_CYCLES = 32'd4,
  parameter logic [31:0] DUMP_BASE    = 32'd8192,
  parameter logic [31:0] DUMP_WORDS   = 32'd11,
  parameter logic [31:0] HALT_INSTR   = 32'hFFFF_FFFF,
  parameter logic [31:0] MAX_CYCLES   = 32'd100000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] instr,
  input  logic        instr_valid,
  input  logic [31:0] mem_rdata,
  input  logic        dump_ready,
  output logic        proc_reset,
  output logic        dump_active,
  output logic [31:0] dump_addr,
  output logic        dump_valid,
  output logic [31:0] dump_data,
  output logic [31:0] dump_idx,
  output logic        done,
  output logic        timeout,
  output logic [31:0] cycle_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_RESET_PROC, S_RUN, S_DRAIN, S_DUMP, S_DONE
  } state_t;

  localparam logic [31:0] RST_LEN = (RESET_CYCLES == 32'd0) ? 32'd1 : RESET_CYCLES;

  state_t      state_q;
  logic [31:0] cnt_q;
  logic [31:0] rd_idx_q;
  logic        proc_reset_q;
  logic        dump_active_q;
  logic [31:0] dump_addr_q;
  logic        dump_valid_q;
  logic [31:0] dump_data_q;
  logic [31:0] dump_idx_q;
  logic        done_q;
  logic        timeout_q;
  logic [31:0] cycle_count_q;

  logic halt, tmo_hit, rst_last, drain_last, accept, last_acc, can_load;

  assign halt       = !instr_valid || (instr == HALT_INSTR);
  assign tmo_hit    = (MAX_CYCLES != 32'd0) && (cycle_count_q == MAX_CYCLES - 32'd1);
  assign rst_last   = (cnt_q == RST_LEN - 32'd1);
  assign drain_last = (DRAIN_CYCLES == 32'd0) || (cnt_q == DRAIN_CYCLES - 32'd1);
  assign accept     = dump_valid_q && dump_ready;
  assign last_acc   = accept && (dump_idx_q == DUMP_WORDS - 32'd1);
  // A new word may be fetched when the output slot is empty or is being emptied this cycle.
  assign can_load   = (!dump_valid_q || dump_ready) && (rd_idx_q < DUMP_WORDS);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      rd_idx_q      <= '0;
      proc_reset_q  <= 1'b1;
      dump_active_q <= 1'b0;
      dump_addr_q   <= '0;
      dump_valid_q  <= 1'b0;
      dump_data_q   <= '0;
      dump_idx_q    <= '0;
      done_q        <= 1'b0;
      timeout_q     <= 1'b0;
      cycle_count_q <= '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_q       <= S_RESET_PROC;
            cnt_q         <= '0;
            proc_reset_q  <= 1'b1;
            done_q        <= 1'b0;
            timeout_q     <= 1'b0;
            cycle_count_q <= '0;
            dump_idx_q    <= '0;
          end
        end
        S_RESET_PROC: begin
          if (rst_last) begin
            state_q      <= S_RUN;
            cnt_q        <= '0;
            proc_reset_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 32'd1;
          end
        end
        S_RUN: begin
          if (cycle_count_q != 32'hFFFF_FFFF) begin
            cycle_count_q <= cycle_count_q + 32'd1;
          end
          if (halt || tmo_hit) begin
            state_q   <= S_DRAIN;
            cnt_q     <= '0;
            timeout_q <= !halt;
          end
        end
        S_DRAIN: begin
          if (drain_last) begin
            cnt_q        <= '0;
            proc_reset_q <= 1'b1;
            if (DUMP_WORDS == 32'd0) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q       <= S_DUMP;
              dump_active_q <= 1'b1;
              dump_addr_q   <= DUMP_BASE;
              rd_idx_q      <= '0;
            end
          end else begin
            cnt_q <= cnt_q + 32'd1;
          end
        end
        S_DUMP: begin
          if (last_acc) begin
            state_q       <= S_DONE;
            dump_valid_q  <= 1'b0;
            dump_active_q <= 1'b0;
            dump_addr_q   <= '0;
            done_q        <= 1'b1;
          end else if (can_load) begin
            dump_data_q  <= mem_rdata;
            dump_idx_q   <= rd_idx_q;
            dump_valid_q <= 1'b1;
            rd_idx_q     <= rd_idx_q + 32'd1;
            // Address tracks the next read index so mem_rdata is ready the following cycle.
            dump_addr_q  <= DUMP_BASE + ((rd_idx_q + 32'd1) << 2);
          end else if (accept) begin
            dump_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign proc_reset  = proc_reset_q;
  assign dump_active = dump_active_q;
  assign dump_addr   = dump_addr_q;
  assign dump_valid  = dump_valid_q;
  assign dump_data   = dump_data_q;
  assign dump_idx    = dump_idx_q;
  assign done        = done_q;
  assign timeout     = timeout_q;
  assign cycle_count = cycle_count_q;

endmodule

// File: tb/tb_run_ctrl.sv
// Bench for run_ctrl: three instances (defaults, MAX_CYCLES=50, DUMP_WORDS=0/DRAIN_CYCLES=0)
// run one at a time; dumped words are checked by a scoreboard fed from the stimulus.
module tb_run_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] instr;
  logic        instr_valid;
  logic        dump_ready;
  logic        start       [3];
  logic        proc_reset  [3];
  logic        dump_active [3];
  logic        dump_valid  [3];
  logic        done        [3];
  logic        timeout     [3];
  logic [31:0] dump_addr   [3];
  logic [31:0] mem_rdata   [3];
  logic [31:0] dump_data   [3];
  logic [31:0] dump_idx    [3];
  logic [31:0] cycle_count [3];

  always #5 clock = ~clock;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  assign mem_rdata[0] = memf(dump_addr[0]);
  assign mem_rdata[1] = memf(dump_addr[1]);
  assign mem_rdata[2] = memf(dump_addr[2]);

  run_ctrl u_def (
    .clock(clock), .reset(reset), .start(start[0]), .instr(instr), .instr_valid(instr_valid),
    .mem_rdata(mem_rdata[0]), .dump_ready(dump_ready), .proc_reset(proc_reset[0]),
    .dump_active(dump_active[0]), .dump_addr(dump_addr[0]), .dump_valid(dump_valid[0]),
    .dump_data(dump_data[0]), .dump_idx(dump_idx[0]), .done(done[0]), .timeout(timeout[0]),
    .cycle_count(cycle_count[0])
  );

  run_ctrl #(.MAX_CYCLES(32'd50)) u_tmo (
    .clock(clock), .reset(reset), .start(start[1]), .instr(instr), .instr_valid(instr_valid),
    .mem_rdata(mem_rdata[1]), .dump_ready(dump_ready), .proc_reset(proc_reset[1]),
    .dump_active(dump_active[1]), .dump_addr(dump_addr[1]), .dump_valid(dump_valid[1]),
    .dump_data(dump_data[1]), .dump_idx(dump_idx[1]), .done(done[1]), .timeout(timeout[1]),
    .cycle_count(cycle_count[1])
  );

  run_ctrl #(.DUMP_WORDS(32'd0), .DRAIN_CYCLES(32'd0)) u_zero (
    .clock(clock), .reset(reset), .start(start[2]), .instr(instr), .instr_valid(instr_valid),
    .mem_rdata(mem_rdata[2]), .dump_ready(dump_ready), .proc_reset(proc_reset[2]),
    .dump_active(dump_active[2]), .dump_addr(dump_addr[2]), .dump_valid(dump_valid[2]),
    .dump_data(dump_data[2]), .dump_idx(dump_idx[2]), .done(done[2]), .timeout(timeout[2]),
    .cycle_count(cycle_count[2])
  );

  typedef struct {
    int          k;
    logic [31:0] idx;
    logic [31:0] data;
  } exp_t;

  exp_t        exp_q[$];
  int          tests = 0;
  int          fails = 0;
  int          low_cnt [3] = '{0, 0, 0};
  int          vld_cnt [3] = '{0, 0, 0};
  int          acc_cnt [3] = '{0, 0, 0};
  bit          seen_vld[3] = '{0, 0, 0};
  bit          stall_q [3] = '{0, 0, 0};
  logic [31:0] hold_data[3];
  logic [31:0] hold_idx [3];
  int          b_low, b_vld, b_acc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%08h), expected %0d (0x%08h)", name, act, act, exp, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  // Monitor: scoreboard pops on each accepted word, plus hold-while-stalled checks.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      for (int k = 0; k < 3; k++) begin
        if (reset) begin
          stall_q[k] = 1'b0;
        end else begin
          if (!proc_reset[k]) low_cnt[k]++;
          if (stall_q[k]) begin
            chk1($sformatf("dut%0d stalled valid held", k), dump_valid[k], 1'b1);
            chk($sformatf("dut%0d stalled data held", k), dump_data[k], hold_data[k]);
            chk($sformatf("dut%0d stalled idx held", k), dump_idx[k], hold_idx[k]);
          end
          if (dump_valid[k]) begin
            vld_cnt[k]++;
            seen_vld[k] = 1'b1;
            chk1($sformatf("dut%0d dump_active with valid", k), dump_active[k], 1'b1);
          end
          if (dump_valid[k] && dump_ready) begin
            acc_cnt[k]++;
            if (exp_q.size() == 0) begin
              tests++;
              fails++;
              $display("FAIL dut%0d unexpected word: got idx %0d, expected no word", k, dump_idx[k]);
            end else begin
              e = exp_q.pop_front();
              chk($sformatf("dut%0d word owner", k), k, e.k);
              chk($sformatf("dut%0d word idx", k), dump_idx[k], e.idx);
              chk($sformatf("dut%0d word data idx %0d", k, e.idx), dump_data[k], e.data);
            end
          end
          stall_q[k]   = dump_valid[k] && !dump_ready;
          hold_data[k] = dump_data[k];
          hold_idx[k]  = dump_idx[k];
        end
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic push_words(input int k, input int n);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back('{k, 32'(i), memf(32'd8192 + 32'(4 * i))});
    end
  endtask

  task automatic snap(input int k);
    b_low = low_cnt[k];
    b_vld = vld_cnt[k];
    b_acc = acc_cnt[k];
  endtask

  task automatic chk_reset(input int k);
    chk1($sformatf("dut%0d reset proc_reset", k), proc_reset[k], 1'b1);
    chk1($sformatf("dut%0d reset dump_active", k), dump_active[k], 1'b0);
    chk($sformatf("dut%0d reset dump_addr", k), dump_addr[k], 32'd0);
    chk1($sformatf("dut%0d reset dump_valid", k), dump_valid[k], 1'b0);
    chk($sformatf("dut%0d reset dump_data", k), dump_data[k], 32'd0);
    chk($sformatf("dut%0d reset dump_idx", k), dump_idx[k], 32'd0);
    chk1($sformatf("dut%0d reset done", k), done[k], 1'b0);
    chk1($sformatf("dut%0d reset timeout", k), timeout[k], 1'b0);
    chk($sformatf("dut%0d reset cycle_count", k), cycle_count[k], 32'd0);
  endtask

  task automatic start_run(input int k);
    start[k] = 1'b1;
    step();
    start[k] = 1'b0;
    chk1($sformatf("dut%0d proc_reset in RESET_PROC", k), proc_reset[k], 1'b1);
    chk1($sformatf("dut%0d start clears done", k), done[k], 1'b0);
    chk1($sformatf("dut%0d start clears timeout", k), timeout[k], 1'b0);
    chk($sformatf("dut%0d start clears cycle_count", k), cycle_count[k], 32'd0);
    step();
    chk1($sformatf("dut%0d RUN after one reset cycle", k), proc_reset[k], 1'b0);
  endtask

  // n RUN cycles in total, the last one presenting a halt.
  task automatic run_halt(input int n, input bit use_instr);
    for (int i = 1; i < n; i++) step();
    if (use_instr) instr = 32'hFFFF_FFFF;
    else instr_valid = 1'b0;
    step();
    instr       = 32'd0;
    instr_valid = 1'b1;
  endtask

  task automatic wait_done(input int k, input int budget, input bit toggle);
    for (int i = 0; i < budget && !done[k]; i++) begin
      if (toggle) dump_ready = ~dump_ready;
      step();
    end
    dump_ready = 1'b1;
    chk1($sformatf("dut%0d done reached", k), done[k], 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, expected $finish");
    $fatal(1);
  end

  initial begin
    reset       = 1'b1;
    instr       = 32'd0;
    instr_valid = 1'b1;
    dump_ready  = 1'b1;
    for (int k = 0; k < 3; k++) start[k] = 1'b0;
    step();
    step();
    for (int k = 0; k < 3; k++) chk_reset(k);
    reset = 1'b0;
    step();

    // Normal run: 20 RUN cycles, start pulse mid-run must be ignored.
    push_words(0, 11);
    snap(0);
    start_run(0);
    for (int i = 1; i < 20; i++) begin
      start[0] = (i == 5);
      step();
    end
    start[0]    = 1'b0;
    instr_valid = 1'b0;
    step();
    instr_valid = 1'b1;
    chk("A cycle_count at halt", cycle_count[0], 32'd20);
    chk1("A timeout at halt", timeout[0], 1'b0);
    for (int i = 0; i < 4; i++) step();
    chk1("A dump_active at DUMP entry", dump_active[0], 1'b1);
    chk("A first dump_addr", dump_addr[0], 32'd8192);
    chk1("A proc_reset in DUMP", proc_reset[0], 1'b1);
    wait_done(0, 100, 1'b0);
    chk("A cycle_count final", cycle_count[0], 32'd20);
    chk1("A timeout final", timeout[0], 1'b0);
    chk("A proc_reset low cycles (RUN+DRAIN)", 32'(low_cnt[0] - b_low), 32'd24);
    chk("A dump_valid cycles", 32'(vld_cnt[0] - b_vld), 32'd11);
    chk("A scoreboard drained", 32'(exp_q.size()), 32'd0);
    chk1("A dump_active in DONE", dump_active[0], 1'b0);
    chk("A dump_addr in DONE", dump_addr[0], 32'd0);

    // Backpressure: ready toggles every cycle, restart from DONE, halt via HALT_INSTR.
    step();
    chk1("B done held in DONE", done[0], 1'b1);
    push_words(0, 11);
    snap(0);
    start_run(0);
    run_halt(7, 1'b1);
    chk("B cycle_count at halt", cycle_count[0], 32'd7);
    wait_done(0, 200, 1'b1);
    chk("B scoreboard drained", 32'(exp_q.size()), 32'd0);
    chk("B words accepted", 32'(acc_cnt[0] - b_acc), 32'd11);
    chk("B proc_reset low cycles", 32'(low_cnt[0] - b_low), 32'd11);

    // Reset after three words have been accepted, then a clean restart.
    push_words(0, 11);
    snap(0);
    start_run(0);
    run_halt(3, 1'b0);
    for (int i = 0; i < 60 && (acc_cnt[0] - b_acc) < 3; i++) step();
    chk("C words before reset", 32'(acc_cnt[0] - b_acc), 32'd3);
    reset = 1'b1;
    step();
    chk_reset(0);
    chk("C words left unsent", 32'(exp_q.size()), 32'd8);
    exp_q.delete();
    reset = 1'b0;
    step();
    push_words(0, 11);
    snap(0);
    start_run(0);
    run_halt(4, 1'b0);
    wait_done(0, 100, 1'b0);
    chk("C restart scoreboard drained", 32'(exp_q.size()), 32'd0);
    chk("C restart words accepted", 32'(acc_cnt[0] - b_acc), 32'd11);
    chk("C restart cycle_count", cycle_count[0], 32'd4);

    // Timeout at MAX_CYCLES=50 with no halt.
    push_words(1, 11);
    snap(1);
    start_run(1);
    for (int i = 0; i < 49; i++) step();
    chk1("D no timeout at 49", timeout[1], 1'b0);
    chk("D cycle_count at 49", cycle_count[1], 32'd49);
    step();
    chk1("D timeout set", timeout[1], 1'b1);
    chk("D cycle_count at timeout", cycle_count[1], 32'd50);
    wait_done(1, 100, 1'b0);
    chk1("D timeout final", timeout[1], 1'b1);
    chk("D cycle_count final", cycle_count[1], 32'd50);
    chk("D scoreboard drained", 32'(exp_q.size()), 32'd0);
    chk("D dump_valid cycles", 32'(vld_cnt[1] - b_vld), 32'd11);
    chk("D proc_reset low cycles", 32'(low_cnt[1] - b_low), 32'd54);

    // Halt in the same cycle the timeout would fire: halt wins.
    push_words(1, 11);
    start_run(1);
    for (int i = 0; i < 49; i++) step();
    instr = 32'hFFFF_FFFF;
    step();
    instr = 32'd0;
    chk1("E timeout on simultaneous halt", timeout[1], 1'b0);
    chk("E cycle_count", cycle_count[1], 32'd50);
    chk1("E in DRAIN", proc_reset[1], 1'b0);
    wait_done(1, 100, 1'b0);
    chk1("E timeout final", timeout[1], 1'b0);
    chk("E scoreboard drained", 32'(exp_q.size()), 32'd0);

    // No dump words and no drain cycles.
    snap(2);
    start_run(2);
    run_halt(5, 1'b0);
    chk1("F not done in DRAIN", done[2], 1'b0);
    chk1("F proc_reset low in DRAIN", proc_reset[2], 1'b0);
    step();
    chk1("F done after one DRAIN cycle", done[2], 1'b1);
    chk1("F dump_valid never seen", seen_vld[2], 1'b0);
    chk1("F dump_active", dump_active[2], 1'b0);
    chk("F cycle_count", cycle_count[2], 32'd5);
    chk("F proc_reset low cycles", 32'(low_cnt[2] - b_low), 32'd6);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
